// File: rtl/dds_sweep_ctrl.sv
// Frequency-sweep controller for a DDS: steps the frequency word through a
// programmed ramp, dwelling a fixed number of output periods on each step.
module dds_sweep_ctrl #(
  parameter int PHASE_WIDTH = 32,
  parameter int STEP_WIDTH  = 16,
  parameter int CYC_WIDTH   = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic                   abort,
  input  logic [PHASE_WIDTH-1:0] f_start,
  input  logic [PHASE_WIDTH-1:0] f_step,
  input  logic                   step_dir,
  input  logic [STEP_WIDTH-1:0]  n_steps,
  input  logic [CYC_WIDTH-1:0]   cyc_per_step,
  input  logic [PHASE_WIDTH:0]   phase_in,
  output logic [PHASE_WIDTH-1:0] frq_word,
  output logic                   busy,
  output logic                   done,
  output logic [STEP_WIDTH-1:0]  step_idx
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t                 state_q, state_d;
  logic                   msb_q, msb_d;
  logic [PHASE_WIDTH-1:0] frq_word_q, frq_word_d;
  logic [PHASE_WIDTH-1:0] f_step_q, f_step_d;
  logic                   dir_q, dir_d;
  logic [STEP_WIDTH-1:0]  step_idx_q, step_idx_d;
  logic [STEP_WIDTH-1:0]  step_last_q, step_last_d;
  logic [CYC_WIDTH-1:0]   cyc_cnt_q, cyc_cnt_d;
  logic [CYC_WIDTH-1:0]   cyc_last_q, cyc_last_d;
  logic                   wrap;
  logic                   unused_phase;

  // Only the extension bit of the accumulator carries period information.
  assign unused_phase = ^phase_in[PHASE_WIDTH-1:0];
  assign wrap         = phase_in[PHASE_WIDTH] ^ msb_q;

  always_comb begin
    state_d     = state_q;
    msb_d       = phase_in[PHASE_WIDTH];
    frq_word_d  = frq_word_q;
    f_step_d    = f_step_q;
    dir_d       = dir_q;
    step_idx_d  = step_idx_q;
    step_last_d = step_last_q;
    cyc_cnt_d   = cyc_cnt_q;
    cyc_last_d  = cyc_last_q;

    case (state_q)
      S_IDLE: begin
        frq_word_d = '0;
        if (start && !abort) begin
          // Counts are held as last-index values; a count of 0 behaves as 1.
          f_step_d    = f_step;
          dir_d       = step_dir;
          step_last_d = (n_steps == '0) ? '0 : n_steps - STEP_WIDTH'(1);
          cyc_last_d  = (cyc_per_step == '0) ? '0 : cyc_per_step - CYC_WIDTH'(1);
          frq_word_d  = f_start;
          step_idx_d  = '0;
          cyc_cnt_d   = '0;
          state_d     = S_RUN;
        end
      end

      S_RUN: begin
        if (abort) begin
          frq_word_d = '0;
          step_idx_d = '0;
          cyc_cnt_d  = '0;
          state_d    = S_IDLE;
        end else if (wrap) begin
          if (cyc_cnt_q < cyc_last_q) begin
            cyc_cnt_d = cyc_cnt_q + CYC_WIDTH'(1);
          end else if (step_idx_q < step_last_q) begin
            cyc_cnt_d  = '0;
            step_idx_d = step_idx_q + STEP_WIDTH'(1);
            frq_word_d = dir_q ? (frq_word_q - f_step_q) : (frq_word_q + f_step_q);
          end else begin
            frq_word_d = '0;
            state_d    = S_DONE;
          end
        end
      end

      S_DONE: begin
        frq_word_d = '0;
        state_d    = S_IDLE;
      end

      default: begin
        frq_word_d = '0;
        state_d    = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      msb_q       <= 1'b0;
      frq_word_q  <= '0;
      f_step_q    <= '0;
      dir_q       <= 1'b0;
      step_idx_q  <= '0;
      step_last_q <= '0;
      cyc_cnt_q   <= '0;
      cyc_last_q  <= '0;
    end else begin
      state_q     <= state_d;
      msb_q       <= msb_d;
      frq_word_q  <= frq_word_d;
      f_step_q    <= f_step_d;
      dir_q       <= dir_d;
      step_idx_q  <= step_idx_d;
      step_last_q <= step_last_d;
      cyc_cnt_q   <= cyc_cnt_d;
      cyc_last_q  <= cyc_last_d;
    end
  end

  assign frq_word = frq_word_q;
  assign step_idx = step_idx_q;
  assign busy     = (state_q == S_RUN);
  assign done     = (state_q == S_DONE);

endmodule

// File: tb/tb_dds_sweep_ctrl.sv
// Directed self-checking bench for dds_sweep_ctrl; the DDS phase MSB is
// driven directly so each toggle is exactly one output period.
module tb_dds_sweep_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        abort;
  logic [31:0] f_start;
  logic [31:0] f_step;
  logic        step_dir;
  logic [15:0] n_steps;
  logic [15:0] cyc_per_step;
  logic [32:0] phase_in;
  logic [31:0] frq_word;
  logic        busy;
  logic        done;
  logic [15:0] step_idx;

  int checks   = 0;
  int failures = 0;

  dds_sweep_ctrl #(
    .PHASE_WIDTH(32),
    .STEP_WIDTH (16),
    .CYC_WIDTH  (16)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .abort       (abort),
    .f_start     (f_start),
    .f_step      (f_step),
    .step_dir    (step_dir),
    .n_steps     (n_steps),
    .cyc_per_step(cyc_per_step),
    .phase_in    (phase_in),
    .frq_word    (frq_word),
    .busy        (busy),
    .done        (done),
    .step_idx    (step_idx)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  // One DDS period: toggle the extension bit, let one rising edge see it.
  task automatic wrap_once();
    phase_in[32] = ~phase_in[32];
    @(negedge clk);
  endtask

  task automatic chk_out(input string tag, input logic [31:0] e_frq, input logic e_busy,
                         input logic e_done, input logic [15:0] e_idx);
    chk({tag, ".frq"},  frq_word,        e_frq);
    chk({tag, ".busy"}, 32'(busy),       32'(e_busy));
    chk({tag, ".done"}, 32'(done),       32'(e_done));
    chk({tag, ".idx"},  32'(step_idx),   32'(e_idx));
  endtask

  task automatic cfg(input logic [31:0] fs, input logic [31:0] st, input logic dir,
                     input logic [15:0] ns, input logic [15:0] cps);
    f_start      = fs;
    f_step       = st;
    step_dir     = dir;
    n_steps      = ns;
    cyc_per_step = cps;
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  initial begin
    rst_n    = 1'b0;
    start    = 1'b0;
    abort    = 1'b0;
    phase_in = '0;
    cfg(32'h0, 32'h0, 1'b0, 16'd0, 16'd0);
    repeat (3) tick();
    chk_out("reset", 32'h0, 1'b0, 1'b0, 16'd0);
    rst_n = 1'b1;
    tick();

    // Wraps in IDLE are ignored and leave the word frozen at 0.
    wrap_once();
    wrap_once();
    chk_out("idle_wrap", 32'h0, 1'b0, 1'b0, 16'd0);

    // Basic ascending sweep, two periods per step.
    cfg(32'h1000_0000, 32'h0800_0000, 1'b0, 16'd3, 16'd2);
    do_start();
    chk_out("basic.s0", 32'h1000_0000, 1'b1, 1'b0, 16'd0);
    wrap_once();
    chk_out("basic.s0c1", 32'h1000_0000, 1'b1, 1'b0, 16'd0);
    repeat (3) tick();
    chk_out("basic.nowrap", 32'h1000_0000, 1'b1, 1'b0, 16'd0);
    wrap_once();
    chk_out("basic.s1", 32'h1800_0000, 1'b1, 1'b0, 16'd1);
    wrap_once();
    wrap_once();
    chk_out("basic.s2", 32'h2000_0000, 1'b1, 1'b0, 16'd2);
    wrap_once();
    chk_out("basic.s2c1", 32'h2000_0000, 1'b1, 1'b0, 16'd2);
    wrap_once();
    chk_out("basic.done", 32'h0, 1'b0, 1'b1, 16'd2);
    tick();
    chk_out("basic.idle", 32'h0, 1'b0, 1'b0, 16'd2);

    // Descending sweep wraps modulo 2^32.
    cfg(32'h0400_0000, 32'h0800_0000, 1'b1, 16'd2, 16'd1);
    do_start();
    chk_out("desc.s0", 32'h0400_0000, 1'b1, 1'b0, 16'd0);
    wrap_once();
    chk_out("desc.s1", 32'hFC00_0000, 1'b1, 1'b0, 16'd1);
    wrap_once();
    chk_out("desc.done", 32'h0, 1'b0, 1'b1, 16'd1);
    tick();

    // Zero counts behave as one step of one period.
    cfg(32'h1234_5678, 32'h0000_0100, 1'b0, 16'd0, 16'd0);
    do_start();
    chk_out("zero.s0", 32'h1234_5678, 1'b1, 1'b0, 16'd0);
    wrap_once();
    chk_out("zero.done", 32'h0, 1'b0, 1'b1, 16'd0);
    tick();
    chk_out("zero.idle", 32'h0, 1'b0, 1'b0, 16'd0);

    // Abort coincident with a step-advancing wrap at step 1.
    cfg(32'h1000_0000, 32'h0800_0000, 1'b0, 16'd3, 16'd2);
    do_start();
    wrap_once();
    wrap_once();
    wrap_once();
    chk_out("abort.pre", 32'h1800_0000, 1'b1, 1'b0, 16'd1);
    abort = 1'b1;
    wrap_once();
    abort = 1'b0;
    chk_out("abort.post", 32'h0, 1'b0, 1'b0, 16'd0);
    wrap_once();
    chk_out("abort.after", 32'h0, 1'b0, 1'b0, 16'd0);

    // Start while busy, with new configuration, is ignored.
    cfg(32'h0000_0100, 32'h0000_0010, 1'b0, 16'd2, 16'd1);
    do_start();
    cfg(32'h0000_ABCD, 32'h0000_0001, 1'b1, 16'd5, 16'd3);
    do_start();
    chk_out("ign.s0", 32'h0000_0100, 1'b1, 1'b0, 16'd0);
    wrap_once();
    chk_out("ign.s1", 32'h0000_0110, 1'b1, 1'b0, 16'd1);
    wrap_once();
    chk_out("ign.done", 32'h0, 1'b0, 1'b1, 16'd1);
    tick();

    // Start together with abort in IDLE does nothing.
    cfg(32'h5555_0000, 32'h0000_0001, 1'b0, 16'd1, 16'd1);
    start = 1'b1;
    abort = 1'b1;
    tick();
    start = 1'b0;
    abort = 1'b0;
    chk_out("startabort", 32'h0, 1'b0, 1'b0, 16'd1);

    // Reset asserted mid-sweep clears outputs immediately.
    cfg(32'h1000_0000, 32'h0800_0000, 1'b0, 16'd3, 16'd2);
    do_start();
    repeat (4) wrap_once();
    chk_out("rst.pre", 32'h2000_0000, 1'b1, 1'b0, 16'd2);
    rst_n = 1'b0;
    #1;
    chk_out("rst.async", 32'h0, 1'b0, 1'b0, 16'd0);
    phase_in[32] = 1'b1;
    tick();
    tick();
    chk_out("rst.held", 32'h0, 1'b0, 1'b0, 16'd0);
    rst_n = 1'b1;
    tick();
    cfg(32'h0400_0000, 32'h0800_0000, 1'b1, 16'd2, 16'd1);
    do_start();
    chk_out("rst.restart", 32'h0400_0000, 1'b1, 1'b0, 16'd0);
    wrap_once();
    chk_out("rst.s1", 32'hFC00_0000, 1'b1, 1'b0, 16'd1);
    wrap_once();
    chk_out("rst.done", 32'h0, 1'b0, 1'b1, 16'd1);
    tick();
    chk_out("rst.idle", 32'h0, 1'b0, 1'b0, 16'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/dds_sweep_ctrl.md
DDS_SWEEP_CTRL -- requirements
Module: dds_sweep_ctrl

Interface
REQ-001 SHALL have parameter PHASE_WIDTH, default 32, DDS accumulator width n.
REQ-002 SHALL have parameter STEP_WIDTH, default 16, width of the step count and step index.
REQ-003 SHALL have parameter CYC_WIDTH, default 16, width of the cycles-per-step count.
REQ-004 SHALL have port clk  in  1  clock; all logic on the rising edge.
REQ-005 SHALL have port rst_n  in  1  reset, asynchronous, active-low.
REQ-006 SHALL have port start  in  1  one-cycle request to begin a sweep.
REQ-007 SHALL have port abort  in  1  terminate the sweep immediately.
REQ-008 SHALL have port f_start  in  PHASE_WIDTH  first frequency word.
REQ-009 SHALL have port f_step  in  PHASE_WIDTH  frequency word increment per step.
REQ-010 SHALL have port step_dir  in  1  0 = ascending (add f_step), 1 = descending (subtract f_step).
REQ-011 SHALL have port n_steps  in  STEP_WIDTH  number of frequency steps in the sweep.
REQ-012 SHALL have port cyc_per_step  in  CYC_WIDTH  number of output periods per step.
REQ-013 SHALL have port phase_in  in  PHASE_WIDTH+1  extended phase accumulator from the DDS.
REQ-014 SHALL have port frq_word  out  PHASE_WIDTH  frequency control word driven to the DDS.
REQ-015 SHALL have port busy  out  1  high while a sweep is running.
REQ-016 SHALL have port done  out  1  one-cycle pulse when a sweep completes normally.
REQ-017 SHALL have port step_idx  out  STEP_WIDTH  index of the current step.

Function
REQ-018 SHALL implement states IDLE, RUN and DONE.
REQ-019 SHALL register phase_in[PHASE_WIDTH] into msb_q every cycle.
REQ-020 SHALL define wrap as phase_in[PHASE_WIDTH] XOR msb_q; one wrap marks one completed output period.
REQ-021 In IDLE, on start=1 with abort=0, SHALL:
  - latch f_step, step_dir, n_steps and cyc_per_step;
  - set frq_word=f_start, step_idx=0, cyc_cnt=0;
  - enter RUN.
REQ-022 SHALL treat a latched n_steps of 0 as 1, and a latched cyc_per_step of 0 as 1.
REQ-023 SHALL ignore configuration inputs and start while in RUN or DONE.
REQ-024 In RUN, SHALL count wraps only; wraps in IDLE and DONE are not counted.
REQ-025 In RUN, on a wrap with cyc_cnt < cyc_per_step-1, SHALL increment cyc_cnt.
REQ-026 In RUN, on a wrap with cyc_cnt = cyc_per_step-1 and step_idx < n_steps-1, SHALL:
  - clear cyc_cnt;
  - increment step_idx;
  - update frq_word to frq_word ± f_step, modulo 2^PHASE_WIDTH, no saturation.
REQ-027 In RUN, on a wrap with cyc_cnt = cyc_per_step-1 and step_idx = n_steps-1, SHALL enter DONE.
REQ-028 The frq_word update SHALL be registered; the DDS sees the new word one cycle after the wrap-detect cycle.
REQ-029 DONE SHALL last exactly one cycle, with done=1 and frq_word=0, then return to IDLE.
REQ-030 abort=1 in RUN SHALL take priority over a wrap in the same cycle:
  - next cycle: IDLE, frq_word=0, step_idx=0, cyc_cnt=0;
  - done not asserted.
REQ-031 start and abort both high in IDLE SHALL leave the block in IDLE.
REQ-032 busy SHALL be 1 exactly while in RUN.
REQ-033 In IDLE, frq_word SHALL be 0, which freezes the DDS phase.
REQ-034 step_idx SHALL hold its final value through DONE and clear on the next start.

Reset
REQ-035 On rst_n=0, SHALL asynchronously set:
  - state IDLE; frq_word=0, busy=0, done=0;
  - step_idx=0, cyc_cnt=0, msb_q=0.
REQ-036 Reset asserted mid-sweep SHALL abandon the sweep without asserting done.
REQ-037 After reset release, the first wrap SHALL be evaluated against msb_q=0.

Verification
REQ-038 Basic sweep: f_start=0x1000_0000, f_step=0x0800_0000, step_dir=0, n_steps=3, cyc_per_step=2 -> frq_word steps 0x1000_0000, 0x1800_0000, 0x2000_0000, two DDS periods each; then a single done pulse; frq_word=0.
REQ-039 Descending wrap-around: f_start=0x0400_0000, f_step=0x0800_0000, step_dir=1, n_steps=2, cyc_per_step=1 -> second word 0xFC00_0000.
REQ-040 Zero counts: n_steps=0, cyc_per_step=0 -> exactly one period at f_start, then done.
REQ-041 Abort: abort coincident with a wrap at step_idx=1 -> next cycle busy=0, frq_word=0, step_idx=0; done never pulses.
REQ-042 Ignored start: start pulsed while busy, with new f_start -> sweep continues unchanged.
REQ-043 Reset mid-sweep: rst_n low at step 2 -> all outputs 0 immediately; restart after release is clean.
